// File: rtl/trans_cntr_bank_pkg.sv
// trans_cntr_bank_pkg: default sizes, op encoding and access FSM states
package trans_cntr_bank_pkg;
   localparam int NUM_CNTR_DEF = 12;
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 32;
   typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} acc_state_e;
endpackage

// File: rtl/trans_cntr_bank_if.sv
// trans_cntr_bank_if: req/ack register access port of the transition counter bank
interface trans_cntr_bank_if
   import trans_cntr_bank_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] dir;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   modport master (output req, we, dir, wdata, input rdata, ack, err);
   modport slave (input req, we, dir, wdata, output rdata, ack, err);
endinterface

// File: rtl/trans_cntr_bank_cntr.sv
// trans_cntr_bank_cntr: one transition counter channel; TRANS_CNTR_SAT_EN selects saturation instead of wrap
module trans_cntr_bank_cntr
   import trans_cntr_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              armed,
   input  logic              en,
   input  logic              clr,
   input  logic              ld,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              probe,
   output logic [DATA_W-1:0] cnt,
   output logic              ovf
);
   logic              probe_q, probe_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              inc, full;
   assign inc = en && armed && (probe != probe_q);
   assign full = &cnt_q;
   // next state with priority clr > load > increment; an edge on a full counter flags ovf
   always_comb begin
      probe_d = probe;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (ld) begin
         cnt_d = ld_data;
         ovf_d = 1'b0;
      end else if (inc) begin
`ifdef TRANS_CNTR_SAT_EN
         cnt_d = full ? cnt_q : cnt_q + 1'b1;
`else
         cnt_d = cnt_q + 1'b1;
`endif
         ovf_d = ovf_q | full;
      end
   end
   // channel state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         probe_q <= 1'b0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         probe_q <= probe_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
   assign cnt = cnt_q;
   assign ovf = ovf_q;
endmodule

// File: rtl/trans_cntr_bank.sv
// trans_cntr_bank: bank of probe transition counters with a req/ack register port
module trans_cntr_bank
   import trans_cntr_bank_pkg::*;
#(
   parameter int NUM_CNTR = NUM_CNTR_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                clr,
   input  logic [NUM_CNTR-1:0] probe,
   trans_cntr_bank_if.slave    bus,
   output logic [NUM_CNTR-1:0] ovf
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] NUM_L = (ADDR_W + 1)'(NUM_CNTR);
   acc_state_e        state_q, state_d;
   logic              armed_q, armed_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] cnt [DEPTH];
   logic              accept, wr;
   // access FSM plus read capture; unpopulated addresses read as zero through the padded mux
   always_comb begin
      accept = (state_q == ST_IDLE) && bus.req;
      state_d = accept ? ST_ACK : ST_IDLE;
      armed_d = 1'b1;
      err_d = accept ? ({1'b0, bus.dir} >= NUM_L) : err_q;
      rdata_d = (accept && bus.we == OP_RD) ? cnt[bus.dir] : rdata_q;
   end
   assign wr = accept && bus.we == OP_WR;
   // control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         err_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         err_q <= err_d;
         rdata_q <= rdata_d;
      end
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_ch
      if (g < NUM_CNTR) begin : g_cnt
         trans_cntr_bank_cntr #(.DATA_W(DATA_W)) u_cntr (
            .clk(clk),
            .reset(reset),
            .armed(armed_q),
            .en(en),
            .clr(clr),
            .ld(wr && bus.dir == ADDR_W'(g)),
            .ld_data(bus.wdata),
            .probe(probe[g]),
            .cnt(cnt[g]),
            .ovf(ovf[g])
         );
      end else begin : g_pad
         assign cnt[g] = '0;
      end
   end
   assign bus.ack = state_q == ST_ACK;
   assign bus.err = err_q;
   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_trans_cntr_bank.sv
// tb_trans_cntr_bank: randomized scoreboard bench for trans_cntr_bank against a behavioural model
module tb_trans_cntr_bank;
   localparam int N = 12;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam logic [DW-1:0] MAX = {DW{1'b1}};

   typedef struct {
      bit            rd;
      logic [DW-1:0] rdata;
      bit            err;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, en, clr;
   logic [N-1:0]  probe;
   logic [N-1:0]  ovf;
   int            checks = 0;
   int            errors = 0;

   exp_t          sb[$];
   logic [DW-1:0] m_cnt [N];
   logic [N-1:0]  m_ovf = '0;
   logic [N-1:0]  m_prev = '0;
   bit            m_arm = 0;
   bit            m_ack = 0;
   logic [DW-1:0] m_rdata = '0;

   trans_cntr_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   trans_cntr_bank #(.NUM_CNTR(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .clr(clr),
      .probe(probe),
      .bus(bus),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: what the bank holds after the coming clock edge, given current inputs.
   function automatic void model_step();
      bit   acc;
      exp_t e;
      if (reset) begin
         foreach (m_cnt[i]) m_cnt[i] = '0;
         m_ovf = '0;
         m_prev = '0;
         m_arm = 0;
         m_ack = 0;
         m_rdata = '0;
         return;
      end
      acc = bus.req && !m_ack;
      if (acc) begin
         e.rd = !bus.we;
         e.err = int'(bus.dir) >= N;
         e.rdata = '0;
         if (int'(bus.dir) < N) e.rdata = m_cnt[bus.dir];
         if (e.rd) m_rdata = e.rdata;
         sb.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
         if (clr) begin
            m_cnt[i] = '0;
            m_ovf[i] = 1'b0;
         end else if (acc && bus.we && int'(bus.dir) == i) begin
            m_cnt[i] = bus.wdata;
            m_ovf[i] = 1'b0;
         end else if (m_arm && en && probe[i] != m_prev[i]) begin
            if (m_cnt[i] == MAX) begin
               m_ovf[i] = 1'b1;
`ifndef TRANS_CNTR_SAT_EN
               m_cnt[i] = '0;
`endif
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
      m_prev = probe;
      m_arm = 1;
      m_ack = acc;
   endfunction

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic rd(input int d);
      bus.req = 1'b1;
      bus.we = 1'b0;
      bus.dir = AW'(d);
      step();
      bus.req = 1'b0;
      step();
   endtask

   task automatic wr(input int d, input logic [DW-1:0] v);
      bus.req = 1'b1;
      bus.we = 1'b1;
      bus.dir = AW'(d);
      bus.wdata = v;
      step();
      bus.req = 1'b0;
      step();
   endtask

   // Monitor: per-cycle state compare, and scoreboard pop whenever the DUT acks.
   always @(posedge clk) begin
      exp_t e;
      #1;
      chk("ack", {31'b0, bus.ack}, {31'b0, m_ack});
      chk("ovf", DW'(ovf), DW'(m_ovf));
      chk("rdata_hold", bus.rdata, m_rdata);
      if (bus.ack) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1 expected no pending access at %0t", $time);
         end else begin
            e = sb.pop_front();
            chk("err", {31'b0, bus.err}, {31'b0, e.err});
            if (e.rd) chk("rdata", bus.rdata, e.rdata);
         end
      end
   end

   initial begin
      reset = 1'b1;
      en = 1'b0;
      clr = 1'b0;
      probe = '0;
      bus.req = 1'b0;
      bus.we = 1'b0;
      bus.dir = '0;
      bus.wdata = '0;
      foreach (m_cnt[i]) m_cnt[i] = '0;
      @(negedge clk);
      step();
      step();
      reset = 1'b0;
      en = 1'b1;
      // probe[0] toggles for 10 cycles
      for (int i = 0; i < 10; i++) begin
         probe[0] = ~probe[0];
         step();
      end
      for (int d = 0; d < N; d++) rd(d);
      // wrap (or saturate) on counter 3
      wr(3, 32'hFFFF_FFFE);
      probe[3] = ~probe[3];
      step();
      probe[3] = ~probe[3];
      step();
      rd(3);
      // write collides with a probe edge on the same counter
      bus.req = 1'b1;
      bus.we = 1'b1;
      bus.dir = 4'd5;
      bus.wdata = 32'h1234_5678;
      probe[5] = ~probe[5];
      step();
      bus.req = 1'b0;
      step();
      rd(5);
      // out-of-range accesses
      rd(12);
      wr(15, 32'hDEAD_BEEF);
      rd(15);
      for (int d = 0; d < N; d++) rd(d);
      // req held high for 6 cycles
      bus.req = 1'b1;
      bus.we = 1'b0;
      bus.dir = 4'd0;
      for (int i = 0; i < 6; i++) step();
      bus.req = 1'b0;
      step();
      // counts frozen with en low
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         probe = N'($urandom);
         step();
      end
      rd(0);
      rd(3);
      en = 1'b1;
      // clear together with a read: read sees pre-clear value
      bus.req = 1'b1;
      bus.we = 1'b0;
      bus.dir = 4'd5;
      clr = 1'b1;
      step();
      clr = 1'b0;
      bus.req = 1'b0;
      step();
      rd(5);
      // reset arrives with a request: no ack must follow
      wr(7, 32'h0000_0042);
      bus.req = 1'b1;
      bus.dir = 4'd7;
      reset = 1'b1;
      step();
      bus.req = 1'b0;
      reset = 1'b0;
      step();
      step();
      rd(7);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         en = $urandom_range(0, 7) != 0;
         clr = $urandom_range(0, 60) == 0;
         probe = probe ^ N'($urandom);
         bus.req = $urandom_range(0, 1);
         bus.we = $urandom_range(0, 1);
         bus.dir = AW'($urandom_range(0, 15));
         bus.wdata = ($urandom_range(0, 2) == 0) ? MAX - DW'($urandom_range(0, 3)) : DW'($urandom);
         step();
      end
      clr = 1'b0;
      bus.req = 1'b0;
      step();
      for (int d = 0; d < N; d++) rd(d);
      step();
      chk("sb_drained", DW'(sb.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
